soc_timer_intc: RTL and testbench
=================================

Name: soc_timer_intc

Overview:
- Parametrised multi-channel timer and interrupt source.
- Replaces the single-bit CP0 timer interrupt feeding the SoC's 6-bit intr vector.
- Memory-mapped on the data-memory bus (ce/we/addr/wtData/rdData); the SoC muxes rdData with DataMem using hit.
- Each channel has a compare match, an auto-reload or one-shot mode, and a maskable pending bit.

Parameters:
- NUM_CH, 4, number of timer channels, legal range 1..6; drives intr[NUM_CH-1:0].
- CNT_W, 32, width of COUNT/COMPARE, legal range 8..32; registers are zero-extended on read, and upper write bits are ignored.
- BASE_ADDR, 32'h0000_1000, block base address; only bits [31:8] are compared.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  bus access strobe.
- we  in  1  1 = write, 0 = read; qualified by ce.
- addr  in  32  byte address.
- wtData  in  32  write data.
- rdData  out  32  read data, combinational.
- hit  out  1  ce & (addr[31:8] == BASE_ADDR[31:8]).
- intr  out  6  interrupt vector to CP0; bits at or above NUM_CH are tied to 0.

Behaviour:
- Address map: addr[7:4] selects the channel; addr[3:2] selects the register; addr[1:0] is ignored.
  - Register 0 = COUNT.
  - Register 1 = COMPARE.
  - Register 2 = CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE.
  - Register 3 = STATUS: bit0 PEND, write-1-to-clear.
  - Channel field 4'hF, register 0 = PRESCALE (16 bit).
  - Other channel indices at or above NUM_CH: reads return 0, writes are ignored.
- Reads: rdData = selected register when hit & ~we; otherwise 0. Zero latency. No side effects.
- Writes: take effect at the rising clk edge when hit & we.
- Reset (rst low, async): COUNT, COMPARE, CTRL, PEND, PRESCALE and the prescale counter all clear to 0. Consequently intr = 0 and rdData = 0. All channels are disabled.
- Prescaler:
  - pre_cnt increments every clk.
  - When pre_cnt == PRESCALE, tick = 1 for that cycle and pre_cnt -> 0.
  - PRESCALE = 0 gives a tick every cycle.
  - A write to PRESCALE also clears pre_cnt.
- Per channel on tick with EN = 1:
  - COUNT == COMPARE:
    - PEND <= 1.
    - AR = 1: COUNT <= 0, EN stays 1.
    - AR = 0: COUNT holds, EN <= 0 (one-shot).
  - Otherwise: COUNT <= COUNT + 1 mod 2^CNT_W. Wrap to 0 raises nothing.
- EN = 0: COUNT and PEND are frozen apart from software writes.
- Interrupt output: intr[i] = PEND[i] & IE[i]. Registered state only, no combinational path from the bus.
- Simultaneous events, same edge:
  - Software COUNT write vs tick increment: the software write wins.
  - Software CTRL write vs one-shot EN clear: the software write wins.
  - STATUS W1C vs a new match: the set wins, PEND stays 1.
  - Writing COMPARE does not affect PEND.
- Reset asserted mid-count: all state clears immediately (async). Counting resumes only after software re-enables a channel.

Test Plan:
- Reset, then read every register of ch0..ch3 and PRESCALE -> all read 0; intr = 6'b0; hit = 1 only for addr 0x1000..0x10FF with ce = 1.
- ch0: COMPARE = 5, CTRL = 3'b111, PRESCALE = 0 -> PEND0 and intr[0] rise on the tick 6 cycles after the CTRL write; COUNT reads 0 afterwards; the period repeats every 6 cycles.
- ch1: COMPARE = 3, CTRL = 3'b101 (one-shot), PRESCALE = 2 -> match after 12 clk; EN reads 0; COUNT holds 3; intr[1] = 1 until STATUS is written with 1, then it goes to 0.
- ch2 IE = 0 with a match -> PEND2 reads 1 but intr[2] = 0; setting IE = 1 asserts intr[2] on the next cycle.
- W1C on the same edge as a new auto-reload match on ch0 -> PEND0 remains 1. COUNT write of 0x10 on a tick edge -> COUNT reads 0x10, not 0x11.
- Write to channel 5 with NUM_CH = 4 -> no state change; reads return 0. Assert rst mid-count -> intr and all registers become 0 without a clock edge.

Source files
------------

// File: rtl/soc_timer_intc.sv
// ---------------------------------------------------------------------------
// soc_timer_intc
//   Multi-channel memory-mapped timer and interrupt source for the SoC's
//   6-bit CP0 interrupt vector. A shared prescaler produces a tick. On each
//   tick, every enabled channel either advances COUNT or matches COMPARE.
//   A match sets PEND and then reloads COUNT to 0 (auto-reload) or disables
//   the channel (one-shot). intr[i] = PEND[i] & IE[i].
//
//   Register map (byte address, addr[1:0] ignored):
//     addr[7:4] = channel, addr[3:2] = register
//       0 COUNT, 1 COMPARE, 2 CTRL {IE,AR,EN}, 3 STATUS {PEND} (W1C)
//     channel 4'hF register 0 = PRESCALE (16 bit)
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   ce      in   bus access strobe
//   we      in   1 = write, 0 = read (qualified by ce)
//   addr    in   [31:0] byte address
//   wtData  in   [31:0] write data
//   rdData  out  [31:0] combinational read data (0 unless hit & ~we)
//   hit     out  ce & address inside the 256-byte window at BASE_ADDR
//   intr    out  [5:0] interrupt vector; bits >= NUM_CH tied to 0
//
// Bus handshake: single-cycle, no wait states. A read is valid in the same
// cycle that ce is high; a write commits on the rising clk edge while
// hit & we are high. There is no ready/stall signal.
// ---------------------------------------------------------------------------
module soc_timer_intc #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        hit,
    output logic [5:0]  intr
);

    logic [3:0]  w_ch;
    logic [1:0]  w_reg;
    logic        w_wr;
    logic        w_tick;
    logic        w_wr_pre;
    logic        w_unused;

    logic [15:0] r_prescale;
    logic [15:0] r_pre_cnt;

    logic [CNT_W-1:0] w_count   [NUM_CH];
    logic [CNT_W-1:0] w_compare [NUM_CH];
    logic [NUM_CH-1:0] w_en;
    logic [NUM_CH-1:0] w_ar;
    logic [NUM_CH-1:0] w_ie;
    logic [NUM_CH-1:0] w_pend;

    assign hit      = ce & (addr[31:8] == BASE_ADDR[31:8]);
    assign w_ch     = addr[7:4];
    assign w_reg    = addr[3:2];
    assign w_wr     = hit & we;
    assign w_wr_pre = w_wr & (w_ch == 4'hF) & (w_reg == 2'd0);

    // Byte-lane bits and write-data bits above the register width are
    // deliberately ignored.
    assign w_unused = ^{addr[1:0], wtData};

    // Tick fires on the cycle the counter equals PRESCALE, so PRESCALE = N
    // gives one tick every N+1 cycles.
    assign w_tick = (r_pre_cnt == r_prescale);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prescale <= '0;
            r_pre_cnt  <= '0;
        end else if (w_wr_pre) begin
            r_prescale <= wtData[15:0];
            r_pre_cnt  <= '0;
        end else if (w_tick) begin
            r_pre_cnt  <= '0;
        end else begin
            r_pre_cnt  <= r_pre_cnt + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [3:0] CH_IDX = 4'(g);

        logic [CNT_W-1:0] r_count;
        logic [CNT_W-1:0] r_compare;
        logic             r_en;
        logic             r_ar;
        logic             r_ie;
        logic             r_pend;
        logic             w_sel;
        logic             w_step;
        logic             w_match;
        logic             w_w1c;

        assign w_sel   = w_wr & (w_ch == CH_IDX);
        assign w_step  = w_tick & r_en;
        assign w_match = w_step & (r_count == r_compare);
        assign w_w1c   = w_sel & (w_reg == 2'd3) & wtData[0];

        // Software writes are tested first so they win over the
        // tick-driven update on the same edge.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_count <= '0;
            end else if (w_sel && w_reg == 2'd0) begin
                r_count <= wtData[CNT_W-1:0];
            end else if (w_match) begin
                if (r_ar) begin
                    r_count <= '0;
                end
            end else if (w_step) begin
                r_count <= r_count + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_compare <= '0;
            end else if (w_sel && w_reg == 2'd1) begin
                r_compare <= wtData[CNT_W-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_en <= 1'b0;
                r_ar <= 1'b0;
                r_ie <= 1'b0;
            end else if (w_sel && w_reg == 2'd2) begin
                r_en <= wtData[0];
                r_ar <= wtData[1];
                r_ie <= wtData[2];
            end else if (w_match && !r_ar) begin
                r_en <= 1'b0;
            end
        end

        // A new match on the same edge as a W1C keeps PEND set.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pend <= 1'b0;
            end else if (w_match) begin
                r_pend <= 1'b1;
            end else if (w_w1c) begin
                r_pend <= 1'b0;
            end
        end

        assign w_count[g]   = r_count;
        assign w_compare[g] = r_compare;
        assign w_en[g]      = r_en;
        assign w_ar[g]      = r_ar;
        assign w_ie[g]      = r_ie;
        assign w_pend[g]    = r_pend;
    end

    always_comb begin
        intr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            intr[i] = w_pend[i] & w_ie[i];
        end
    end

    always_comb begin
        rdData = '0;
        if (hit && !we) begin
            if (w_ch == 4'hF) begin
                if (w_reg == 2'd0) begin
                    rdData = {16'd0, r_prescale};
                end
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_ch == 4'(i)) begin
                        case (w_reg)
                            2'd0:    rdData = 32'(w_count[i]);
                            2'd1:    rdData = 32'(w_compare[i]);
                            2'd2:    rdData = {29'd0, w_ie[i], w_ar[i], w_en[i]};
                            default: rdData = {31'd0, w_pend[i]};
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_soc_timer_intc.sv
// ---------------------------------------------------------------------------
// tb_soc_timer_intc
//   Bench for soc_timer_intc (NUM_CH = 4, CNT_W = 32). The driver issues one
//   bus operation per cycle and pushes the expected rdData, hit and intr for
//   that cycle, taken from a reference model of the timer rules. A monitor
//   pops the queues on the falling edge and compares them with the DUT
//   outputs. The model is updated at each rising edge.
// ---------------------------------------------------------------------------
module tb_soc_timer_intc;

    localparam int NCH = 4;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wtData;
    logic [31:0] rdData;
    logic        hit;
    logic [5:0]  intr;

    int n_checks;
    int n_errors;

    logic [31:0] exp_q[$];
    logic [31:0] exp_hit_q[$];
    logic [31:0] exp_intr_q[$];

    // Reference model state
    bit [31:0] m_count [NCH];
    bit [31:0] m_cmp   [NCH];
    bit        m_en    [NCH];
    bit        m_ar    [NCH];
    bit        m_ie    [NCH];
    bit        m_pend  [NCH];
    bit [15:0] m_prescale;
    bit [15:0] m_pre;

    soc_timer_intc #(
        .NUM_CH    (4),
        .CNT_W     (32),
        .BASE_ADDR (32'h0000_1000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .wtData (wtData),
        .rdData (rdData),
        .hit    (hit),
        .intr   (intr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_count[i] = 0;
            m_cmp[i]   = 0;
            m_en[i]    = 0;
            m_ar[i]    = 0;
            m_ie[i]    = 0;
            m_pend[i]  = 0;
        end
        m_prescale = 0;
        m_pre      = 0;
    endfunction

    function automatic bit model_hit(input bit c, input bit [31:0] a);
        return c && (a[31:8] == 24'h00_0010);
    endfunction

    function automatic bit [31:0] model_read(input bit c, input bit w, input bit [31:0] a);
        int ch;
        int rg;
        ch = int'(a[7:4]);
        rg = int'(a[3:2]);
        if (!model_hit(c, a) || w) return 0;
        if (ch == 15) return (rg == 0) ? {16'd0, m_prescale} : 32'd0;
        if (ch >= NCH) return 0;
        case (rg)
            0:       return m_count[ch];
            1:       return m_cmp[ch];
            2:       return {29'd0, m_ie[ch], m_ar[ch], m_en[ch]};
            default: return {31'd0, m_pend[ch]};
        endcase
    endfunction

    function automatic bit [31:0] model_intr();
        bit [31:0] v;
        v = 0;
        for (int i = 0; i < NCH; i++) v[i] = m_pend[i] & m_ie[i];
        return v;
    endfunction

    // Applies one rising edge: timer rules on the old state, then the
    // software write, which takes priority except that a fresh match keeps
    // PEND set against a W1C.
    function automatic void model_step(input bit c, input bit w, input bit [31:0] a,
                                       input bit [31:0] d);
        bit tick;
        bit matched [NCH];
        int ch;
        int rg;
        tick = (m_pre == m_prescale);
        m_pre = tick ? 16'd0 : m_pre + 16'd1;
        for (int i = 0; i < NCH; i++) begin
            matched[i] = 0;
            if (m_en[i] && tick) begin
                if (m_count[i] == m_cmp[i]) begin
                    matched[i] = 1;
                    m_pend[i]  = 1;
                    if (m_ar[i]) m_count[i] = 0;
                    else         m_en[i]    = 0;
                end else begin
                    m_count[i] = m_count[i] + 1;
                end
            end
        end
        ch = int'(a[7:4]);
        rg = int'(a[3:2]);
        if (model_hit(c, a) && w) begin
            if (ch == 15 && rg == 0) begin
                m_prescale = d[15:0];
                m_pre      = 0;
            end else if (ch < NCH) begin
                case (rg)
                    0: m_count[ch] = d;
                    1: m_cmp[ch]   = d;
                    2: begin
                        m_en[ch] = d[0];
                        m_ar[ch] = d[1];
                        m_ie[ch] = d[2];
                    end
                    default: if (d[0] && !matched[ch]) m_pend[ch] = 0;
                endcase
            end
        end
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1; drives one bus operation for a full cycle.
    task automatic bus_cycle(input bit c, input bit w, input bit [31:0] a, input bit [31:0] d);
        ce     = c;
        we     = w;
        addr   = a;
        wtData = d;
        exp_q.push_back(model_read(c, w, a));
        exp_hit_q.push_back({31'd0, model_hit(c, a)});
        exp_intr_q.push_back(model_intr());
        @(posedge clk);
        model_step(c, w, a, d);
        #1;
    endtask

    task automatic wr(input bit [31:0] a, input bit [31:0] d);
        bus_cycle(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input bit [31:0] a);
        bus_cycle(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            chk("rdData", rdData, exp_q.pop_front());
            chk("hit", {31'd0, hit}, exp_hit_q.pop_front());
            chk("intr", {26'd0, intr}, exp_intr_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int chans [6];
        n_checks = 0;
        n_errors = 0;
        chans = '{0, 1, 2, 3, 5, 15};
        rst    = 1'b1;
        ce     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wtData = '0;
        model_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ce   = 1'b1;
        addr = 32'h0000_1000;
        #1;
        chk("reset_intr", {26'd0, intr}, 32'd0);
        chk("reset_rd_count0", rdData, 32'd0);
        rst = 1'b1;
        ce  = 1'b0;

        // Reset values of every register and address decode
        for (int ch = 0; ch < NCH; ch++)
            for (int rg = 0; rg < 4; rg++) rd(32'h1000 + 32'(ch * 16 + rg * 4));
        rd(32'h0000_10F0);
        rd(32'h0000_0FFC);
        rd(32'h0000_1100);
        rd(32'h0000_10FF);
        bus_cycle(1'b0, 1'b0, 32'h0000_1000, 32'd0);

        // ch0 auto-reload with IE, prescale 0
        wr(32'h0000_10F0, 32'd0);
        wr(32'h0000_1004, 32'd5);
        wr(32'h0000_1008, 32'd7);
        for (int i = 0; i < 7; i++) begin
            rd(32'h0000_1000);
            rd(32'h0000_100C);
        end
        wr(32'h0000_100C, 32'd1);
        rd(32'h0000_100C);
        wr(32'h0000_1008, 32'd0);
        wr(32'h0000_100C, 32'd1);

        // ch1 one-shot with prescale 2
        wr(32'h0000_10F0, 32'd2);
        wr(32'h0000_1014, 32'd3);
        wr(32'h0000_1018, 32'd5);
        for (int i = 0; i < 8; i++) begin
            rd(32'h0000_1010);
            rd(32'h0000_1018);
        end
        rd(32'h0000_101C);
        wr(32'h0000_101C, 32'd1);
        rd(32'h0000_101C);
        rd(32'h0000_1010);

        // ch2 match with IE = 0, then IE = 1
        wr(32'h0000_10F0, 32'd0);
        wr(32'h0000_1024, 32'd1);
        wr(32'h0000_1028, 32'd1);
        idle(4);
        rd(32'h0000_102C);
        wr(32'h0000_1028, 32'd4);
        rd(32'h0000_102C);
        wr(32'h0000_102C, 32'd1);

        // ch0: W1C issued exactly on the edge of a new auto-reload match
        wr(32'h0000_1000, 32'd0);
        wr(32'h0000_1004, 32'd2);
        wr(32'h0000_1008, 32'd7);
        for (int i = 0; i < 12; i++) begin
            if (m_en[0] && m_pre == m_prescale && m_count[0] == m_cmp[0])
                wr(32'h0000_100C, 32'd1);
            else
                rd(32'h0000_100C);
        end
        // COUNT write on a tick edge while counting
        wr(32'h0000_1004, 32'd100);
        wr(32'h0000_1000, 32'h10);
        rd(32'h0000_1000);

        // Channel 5 does not exist
        for (int rg = 0; rg < 4; rg++) wr(32'h1050 + 32'(rg * 4), 32'hFFFF_FFFF);
        for (int rg = 0; rg < 4; rg++) rd(32'h1050 + 32'(rg * 4));
        rd(32'h0000_10F4);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            int op;
            int ch;
            int rg;
            bit [31:0] a;
            bit [31:0] d;
            op = int'($urandom_range(0, 9));
            ch = chans[$urandom_range(0, 5)];
            rg = int'($urandom_range(0, 3));
            a  = 32'h1000 + 32'(ch * 16 + rg * 4) + 32'($urandom_range(0, 3));
            case (rg)
                0:       d = (ch == 15) ? (($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 6));
                1:       d = 32'($urandom_range(0, 6));
                2:       d = ($urandom() & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
                default: d = 32'($urandom_range(0, 1));
            endcase
            if (op < 4)       rd(a);
            else if (op < 8)  wr(a, d);
            else if (op == 8) bus_cycle(1'b0, 1'b1, a, d);
            else              rd(32'h0000_2000 + 32'($urandom_range(0, 255)));
        end

        // Asynchronous reset in the middle of counting
        wr(32'h0000_10F0, 32'd0);
        wr(32'h0000_1004, 32'd0);
        wr(32'h0000_1008, 32'd7);
        rd(32'h0000_100C);
        chk("pre_reset_intr0", {26'd0, intr}, model_intr());
        ce   = 1'b1;
        we   = 1'b0;
        addr = 32'h0000_1004;
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("async_intr", {26'd0, intr}, 32'd0);
        chk("async_rd_compare0", rdData, 32'd0);
        addr = 32'h0000_1008;
        #1;
        chk("async_rd_ctrl0", rdData, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) rd(32'h0000_1000);
        rd(32'h0000_1008);
        rd(32'h0000_10F0);

        idle(1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
